// File: rtl/pc_ctrl_if.sv
// Bus between the decoder/ALU side and the fetch sequencer.
// Carries:
//   control : start, stall, halt_req
//   branch  : branch_en, br_kind, notequal, lessthan, lut_idx
//   table   : lut_wr_en, lut_wr_addr, lut_wr_data
//   status  : prog_ctr, running, done, br_taken (sequencer outputs)
// master = decoder/testbench side, slave = pc_ctrl.
interface pc_ctrl_if #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned LUT_AW = 5
);
  logic              start;
  logic              stall;
  logic              halt_req;
  logic              branch_en;
  logic              br_kind;
  logic              notequal;
  logic              lessthan;
  logic [LUT_AW-1:0] lut_idx;
  logic              lut_wr_en;
  logic [LUT_AW-1:0] lut_wr_addr;
  logic [PC_W-1:0]   lut_wr_data;
  logic [PC_W-1:0]   prog_ctr;
  logic              running;
  logic              done;
  logic              br_taken;

  modport master (
    output start, stall, halt_req, branch_en, br_kind, notequal, lessthan,
           lut_idx, lut_wr_en, lut_wr_addr, lut_wr_data,
    input  prog_ctr, running, done, br_taken
  );

  modport slave (
    input  start, stall, halt_req, branch_en, br_kind, notequal, lessthan,
           lut_idx, lut_wr_en, lut_wr_addr, lut_wr_data,
    output prog_ctr, running, done, br_taken
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter and fetch sequencer for the single-cycle core.
// Chooses the next fetch address from increment, restart, or a branch
// target held in a loadable lookup table indexed by the immediate.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : pc_ctrl_if slave (decoder/ALU inputs, table write port,
//              registered prog_ctr/running/done/br_taken outputs)
module pc_ctrl #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned LUT_AW = 5
) (
  input  logic    clk,
  input  logic    reset_n,
  pc_ctrl_if.slave bus
);

  localparam int unsigned LUT_N = 1 << LUT_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            br_q, br_d;
  logic            running_q, done_q;
  logic [PC_W-1:0] lut_q [LUT_N];
  logic [PC_W-1:0] target_c;
  logic            cond_c;

  // Combinational table read; a same-cycle write is not yet visible here.
  assign target_c = lut_q[bus.lut_idx];
  assign cond_c   = bus.br_kind ? bus.lessthan : bus.notequal;

  // Next-state / next-PC selection in priority order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    br_d    = br_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        br_d = 1'b0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.start) begin
          pc_d = '0;
          br_d = 1'b0;
        end else if (bus.stall) begin
          // Hold everything; decoder re-presents the instruction.
          pc_d = pc_q;
        end else if (bus.halt_req) begin
          state_d = HALT;
          br_d    = 1'b0;
        end else if (bus.branch_en && cond_c) begin
          pc_d = target_c;
          br_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
          br_d = 1'b0;
        end
      end
      HALT: begin
        br_d = 1'b0;
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        br_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      br_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      br_q      <= br_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALT);
    end
  end

  // Target table: write in any state, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(LUT_N); i++) lut_q[i] <= '0;
    end else if (bus.lut_wr_en) begin
      lut_q[bus.lut_wr_addr] <= bus.lut_wr_data;
    end
  end

  assign bus.prog_ctr = pc_q;
  assign bus.br_taken = br_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;

endmodule
